// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and helpers for the multi-port register file.
// Clear vectors are padded to MAX_DEPTH, so ADDR_W must not exceed 8.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_DEPTH  = 256;

  typedef logic [MAX_DEPTH-1:0] clr_vec_t;

  function automatic int clr_popcnt(input clr_vec_t v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++)
      n = n + int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits and the pending-register counter.
// An issue to a register beats a same-edge writeback clear of that register.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                    RF_clk,
  input  logic                    RF_rst,
  input  logic                    RF_ena,
  input  logic                    RF_W0,
  input  logic [ADDR_W-1:0]       Rdc0,
  input  logic                    RF_W1,
  input  logic [ADDR_W-1:0]       Rdc1,
  input  logic                    RF_issue,
  input  logic [ADDR_W-1:0]       RF_issue_c,
  output logic [(1<<ADDR_W)-1:0]  pend,
  output logic [ADDR_W:0]         pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] set_v;
  logic [DEPTH-1:0] hit_v;
  logic [DEPTH-1:0] clr_v;
  clr_vec_t         clr_ext;
  logic             inc;
  logic [ADDR_W:0]  dec;
  logic [ADDR_W:0]  cnt_q;

  always_comb begin
    set_v   = '0;
    hit_v   = '0;
    clr_ext = '0;
    for (int r = 0; r < DEPTH; r++) begin
      set_v[r] = RF_issue && (RF_issue_c == ADDR_W'(r));
      hit_v[r] = (RF_W0 && (Rdc0 == ADDR_W'(r)))
              || (RF_W1 && (Rdc1 == ADDR_W'(r)));
    end
    if (ZERO_REG != 0) begin
      set_v[0] = 1'b0;
      hit_v[0] = 1'b0;
    end
    // only registers that are actually pending lower the count
    clr_v = hit_v & ~set_v & pend_q;
    clr_ext[DEPTH-1:0] = clr_v;
    dec = (ADDR_W+1)'(clr_popcnt(clr_ext));
    inc = |(set_v & ~pend_q);
  end

  always_ff @(posedge RF_clk or posedge RF_rst) begin
    if (RF_rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else if (RF_ena) begin
      pend_q <= (pend_q | set_v) & ~clr_v;
      cnt_q  <= cnt_q + {{ADDR_W{1'b0}}, inc} - dec;
    end
  end

  assign pend     = pend_q;
  assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2-write / NUM_RD-read register file with pending scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     RF_clk,
  input  logic                     RF_rst,
  input  logic                     RF_ena,
  input  logic                     RF_W0,
  input  logic [ADDR_W-1:0]        Rdc0,
  input  logic [DATA_W-1:0]        Rd0,
  input  logic                     RF_W1,
  input  logic [ADDR_W-1:0]        Rdc1,
  input  logic [DATA_W-1:0]        Rd1,
  input  logic [NUM_RD*ADDR_W-1:0] Rsc,
  output logic [NUM_RD*DATA_W-1:0] Rs,
  output logic [NUM_RD-1:0]        RF_busy,
  input  logic                     RF_issue,
  input  logic [ADDR_W-1:0]        RF_issue_c,
  output logic [ADDR_W:0]          RF_pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              en;
  logic              w0_ok;
  logic              w1_ok;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data;
  logic              busy;

  assign en    = RF_ena & ~RF_rst;
  assign w0_ok = RF_W0 && !((ZERO_REG != 0) && (Rdc0 == '0));
  assign w1_ok = RF_W1 && !((ZERO_REG != 0) && (Rdc1 == '0));

  // port 1 is assigned last, so it wins a same-index conflict
  always_ff @(posedge RF_clk or posedge RF_rst) begin
    if (RF_rst) begin
      for (int r = 0; r < DEPTH; r++)
        mem[r] <= '0;
    end else if (RF_ena) begin
      if (w0_ok) mem[Rdc0] <= Rd0;
      if (w1_ok) mem[Rdc1] <= Rd1;
    end
  end

  always_comb begin
    Rs      = '0;
    RF_busy = '0;
    idx     = '0;
    data    = '0;
    busy    = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      idx  = Rsc[k*ADDR_W +: ADDR_W];
      data = mem[idx];
      busy = pend[idx];
`ifdef RF_BYPASS_EN
      if (w0_ok && (Rdc0 == idx)) begin
        data = Rd0;
        busy = RF_issue && (RF_issue_c == idx);
      end
      if (w1_ok && (Rdc1 == idx)) begin
        data = Rd1;
        busy = RF_issue && (RF_issue_c == idx);
      end
`endif
      if (!en || ((ZERO_REG != 0) && (idx == '0))) begin
        data = '0;
        busy = 1'b0;
      end
      Rs[k*DATA_W +: DATA_W] = data;
      RF_busy[k] = busy;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .RF_clk     (RF_clk),
    .RF_rst     (RF_rst),
    .RF_ena     (RF_ena),
    .RF_W0      (RF_W0),
    .Rdc0       (Rdc0),
    .RF_W1      (RF_W1),
    .Rdc1       (Rdc1),
    .RF_issue   (RF_issue),
    .RF_issue_c (RF_issue_c),
    .pend       (pend),
    .pend_cnt   (RF_pend_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random stimulus against a behavioural model.
// Four read ports, zero register enabled.
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b1;
  logic         w0 = 1'b0;
  logic [4:0]   rdc0 = '0;
  logic [31:0]  rd0 = '0;
  logic         w1 = 1'b0;
  logic [4:0]   rdc1 = '0;
  logic [31:0]  rd1 = '0;
  logic [19:0]  rsc = '0;
  logic [127:0] rs;
  logic [3:0]   busy;
  logic         issue = 1'b0;
  logic [4:0]   issue_c = '0;
  logic [5:0]   cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_pend;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1)
  ) dut (
    .RF_clk(clk), .RF_rst(rst), .RF_ena(ena),
    .RF_W0(w0), .Rdc0(rdc0), .Rd0(rd0),
    .RF_W1(w1), .Rdc1(rdc1), .Rd1(rd1),
    .Rsc(rsc), .Rs(rs), .RF_busy(busy),
    .RF_issue(issue), .RF_issue_c(issue_c),
    .RF_pend_cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: architectural state after each enabled edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_pend = '0;
    end else if (ena) begin
      for (int r = 1; r < 32; r++) begin
        if (issue && issue_c == 5'(r))
          m_pend[r] = 1'b1;
        else if ((w0 && rdc0 == 5'(r)) || (w1 && rdc1 == 5'(r)))
          m_pend[r] = 1'b0;
      end
      if (w0 && rdc0 != 0) m_reg[rdc0] = rd0;
      if (w1 && rdc1 != 0) m_reg[rdc1] = rd1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    v = m_reg[a];
`ifdef RF_BYPASS_EN
    if (w1 && rdc1 == a) v = rd1;
    else if (w0 && rdc0 == a) v = rd0;
`endif
    if (!ena || a == 0) v = '0;
    return v;
  endfunction

  function automatic logic exp_bz(input logic [4:0] a);
    logic b;
    b = m_pend[a];
`ifdef RF_BYPASS_EN
    if ((w1 && rdc1 == a) || (w0 && rdc0 == a))
      b = issue && issue_c == a;
`endif
    if (!ena || a == 0) b = 1'b0;
    return b;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("rs%0d", k), 128'(rs[k*32 +: 32]),
            128'(exp_rd(rsc[k*5 +: 5])));
        chk($sformatf("busy%0d", k), 128'(busy[k]),
            128'(exp_bz(rsc[k*5 +: 5])));
      end
      chk("pend_cnt", 128'(cnt), 128'($countones(m_pend)));
    end
  end

  task automatic set_rsc(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [4:0] d);
    rsc = {d, c, b, a};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    w0 = 1'b0;
    w1 = 1'b0;
    issue = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_rs", rs, 128'h0);
    chk("rst_cnt", 128'(cnt), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    @(negedge clk);
    #1 rst = 1'b0;

    // r3 and r7, then async reset mid-cycle
    w0 = 1; rdc0 = 5'd3; rd0 = 32'hDEADBEEF;
    w1 = 1; rdc1 = 5'd7; rd1 = 32'hDEADBEEF;
    set_rsc(5'd3, 5'd7, 5'd3, 5'd7);
    tick();
    chk("r3", 128'(rs[31:0]), 128'hDEADBEEF);
    chk("r7", 128'(rs[63:32]), 128'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rs", rs, 128'h0);
    chk("mid_rst_cnt", 128'(cnt), 128'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_r3", 128'(rs[31:0]), 128'h0);

    // issue r9 twice, then r12
    issue = 1; issue_c = 5'd9;
    tick();
    chk("cnt_a", 128'(cnt), 128'd1);
    issue = 1; issue_c = 5'd9;
    tick();
    chk("cnt_b", 128'(cnt), 128'd1);
    issue = 1; issue_c = 5'd12;
    tick();
    chk("cnt_c", 128'(cnt), 128'd2);

    w0 = 1; rdc0 = 5'd9; rd0 = 32'h99;
    w1 = 1; rdc1 = 5'd12; rd1 = 32'h12;
    set_rsc(5'd9, 5'd12, 5'd9, 5'd12);
    tick();
    chk("cnt_d", 128'(cnt), 128'd0);
    chk("busy_9_12", 128'(busy), 128'h0);

    // issue and write r4 in one edge
    issue = 1; issue_c = 5'd4;
    w0 = 1; rdc0 = 5'd4; rd0 = 32'h55;
    set_rsc(5'd4, 5'd4, 5'd4, 5'd4);
    tick();
    chk("r4", 128'(rs[31:0]), 128'h55);
    chk("busy_r4", 128'(busy[0]), 128'd1);
    chk("cnt_e", 128'(cnt), 128'd1);

    // port 1 wins r5
    w0 = 1; rdc0 = 5'd5; rd0 = 32'h11;
    w1 = 1; rdc1 = 5'd5; rd1 = 32'h22;
    set_rsc(5'd5, 5'd5, 5'd5, 5'd5);
    tick();
    chk("r5_all", rs, {4{32'h22}});

    // zero register
    w0 = 1; rdc0 = 5'd0; rd0 = 32'hFFFFFFFF;
    issue = 1; issue_c = 5'd0;
    set_rsc(5'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("r0_rs", rs, 128'h0);
    chk("r0_busy", 128'(busy), 128'h0);
    chk("r0_cnt", 128'(cnt), 128'd1);

    // two ports clearing one pending register
    issue = 1; issue_c = 5'd10;
    tick();
    chk("cnt_f", 128'(cnt), 128'd2);
    w0 = 1; rdc0 = 5'd10; rd0 = 32'hA0;
    w1 = 1; rdc1 = 5'd10; rd1 = 32'hA1;
    set_rsc(5'd10, 5'd4, 5'd10, 5'd10);
    tick();
    chk("cnt_g", 128'(cnt), 128'd1);
    chk("r10", 128'(rs[31:0]), 128'hA1);

    // same-cycle read of a register being written
    set_rsc(5'd2, 5'd2, 5'd2, 5'd2);
    w0 = 1; rdc0 = 5'd2; rd0 = 32'hA5A5A5A5;
    #1;
`ifdef RF_BYPASS_EN
    chk("r2_same", 128'(rs[31:0]), 128'hA5A5A5A5);
`else
    chk("r2_same", 128'(rs[31:0]), 128'h0);
`endif
    tick();
    chk("r2_next", 128'(rs[31:0]), 128'hA5A5A5A5);

    // disabled block
    ena = 0;
    w0 = 1; rdc0 = 5'd6; rd0 = 32'h66;
    issue = 1; issue_c = 5'd6;
    set_rsc(5'd6, 5'd4, 5'd5, 5'd6);
    #1;
    chk("dis_rs", rs, 128'h0);
    chk("dis_busy", 128'(busy), 128'h0);
    tick();
    ena = 1;
    #1;
    chk("dis_r6", 128'(rs[31:0]), 128'h0);
    chk("dis_cnt", 128'(cnt), 128'd1);

    // random traffic, checked by the compare process
    for (int n = 0; n < 200; n++) begin
      ena = ($urandom_range(0, 7) != 0);
      w0 = 1'($urandom_range(0, 1));
      rdc0 = 5'($urandom_range(0, 31));
      rd0 = $urandom;
      w1 = 1'($urandom_range(0, 1));
      rdc1 = ($urandom_range(0, 3) == 0) ? rdc0 : 5'($urandom_range(0, 31));
      rd1 = $urandom;
      issue = 1'($urandom_range(0, 1));
      issue_c = ($urandom_range(0, 3) == 0) ? rdc0 : 5'($urandom_range(0, 31));
      rsc = 20'($urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
